input_source_arbiter: RTL and testbench
=======================================

INPUT_SOURCE_ARBITER -- requirements
Module: input_source_arbiter

Interface
REQ-001 Parameter STEP_LIMIT, default 10: maximum per-report mouse delta magnitude applied to an axis.
REQ-002 Parameter IDLE_CYCLES, default 24'd12_000_000: number of clk_sys cycles without a mouse report that releases mouse ownership.
REQ-003 Port clk_sys, input, 1: system clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port joy_0, input, 16: player-1 digital joystick bits.
REQ-006 Port joya_0, input, 16: player-1 analog stick, signed X in [7:0] and signed Y in [15:8].
REQ-007 Port ps2_mouse, input, 25: [24] toggle strobe, [5]/[4] Y/X sign, [23:16] Y byte, [15:8] X byte, [1:0] buttons.
REQ-008 Port cpu_halt, input, 1: core halted; forces joystick ownership.
REQ-009 Port ax, output, 8: signed paddle/analog X to the core.
REQ-010 Port ay, output, 8: signed paddle/analog Y to the core.
REQ-011 Port j0, output, 8: player-1 digital/fire bits to the core.
REQ-012 Port src, output, 2: current owner, encoded 0=JOY, 1=MOUSE, 2=HALT.

Function
REQ-013 States: JOY, MOUSE, HALT; state, accumulators mx/my (signed 9-bit), idle counter and strobe history are registers.
REQ-014 A report is detected when ps2_mouse[24] differs from its registered previous value and the primed flag is set.
REQ-015 Primed flag clears on reset and sets after the first post-reset cycle, so the strobe level present at reset release is never a report.
REQ-016 Priority each cycle: cpu_halt > joya_0 nonzero > report > idle timeout.
REQ-017 Any state with cpu_halt=1 goes to HALT and clears mx, my and the idle counter.
REQ-018 HALT with cpu_halt=0 goes to JOY; reports are ignored while in HALT.
REQ-019 JOY or MOUSE with joya_0 nonzero goes to (or stays in) JOY and clears mx, my; a coincident report is discarded.
REQ-020 JOY with a report goes to MOUSE and applies the report to mx/my starting from 0.
REQ-021 MOUSE with a report applies the report and clears the idle counter.
REQ-022 MOUSE without a report increments the idle counter; at IDLE_CYCLES-1 it goes to JOY and clears mx, my and the counter.
REQ-023 Delta is a 9-bit sign-extended value {sign, byte}, clamped to [-STEP_LIMIT, +STEP_LIMIT].
REQ-024 The new accumulator is old plus clamped delta, computed in 10 bits, then saturated to [-128, +127]; no wrap-around.
REQ-025 Outputs are registered: in MOUSE, ax=mx[7:0], ay=my[7:0], j0={joy_0[7], ps2_mouse[1:0], joy_0[4:0]}.
REQ-026 In JOY and HALT, ax=joya_0[7:0], ay=joya_0[15:8], j0=joy_0[7:0].
REQ-027 Latency: a report in cycle N updates mx/my/state at the end of cycle N; ax/ay/j0/src reflect the update at the end of cycle N+1.

Reset
REQ-028 reset_n low asynchronously forces state JOY, mx=my=0, idle counter 0, strobe history 0, primed 0.
REQ-029 During reset, outputs are ax=0, ay=0, j0=0, src=0.
REQ-030 Reset asserted mid-accumulation discards all mouse state; the first report after release starts from 0.

Structure
REQ-031 Package atari_input_pkg holds the src_t enum (JOY/MOUSE/HALT), AXIS_MIN=-128, AXIS_MAX=127 and the 9-bit signed axis type.
REQ-032 Per-axis delta clamp and saturating accumulate are a sub-module axis_accum, instantiated twice (X, Y).

Verification
REQ-033 Reset release with ps2_mouse[24]=1 held -> no report; src=0 and ax=joya_0[7:0] indefinitely.
REQ-034 Toggle with X byte=0x05, sign=0 -> src=1, ax=5 two cycles later; three further toggles of X=+40 -> ax=35 (clamped to +10 per step).
REQ-035 Thirteen toggles of X=-100 (sign=1) from 0 -> ax=0x80 (-128), with no wrap to positive.
REQ-036 In MOUSE, joya_0=16'h0100 coincident with a toggle -> src=0, ay=0x01, mx/my cleared, report discarded.
REQ-037 In MOUSE, cpu_halt=1 for 5 cycles -> src=2, toggles ignored; cpu_halt=0 -> src=0, ax=joya_0[7:0].
REQ-038 With IDLE_CYCLES=16, a report followed by 15 idle cycles -> src returns to 0; with 14 idle cycles and then a report -> src stays 1.

Source files
------------

// File: rtl/atari_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atari_input_pkg
// Purpose  : Shared types and constants for the input source arbiter.
//            src_t  - current owner of the core's input (JOY/MOUSE/HALT)
//            axis_t - signed 9-bit mouse axis accumulator
// Revision : 1.0 - initial release
// ============================================================================
package atari_input_pkg;

  typedef enum logic [1:0] {
    SRC_JOY   = 2'd0,
    SRC_MOUSE = 2'd1,
    SRC_HALT  = 2'd2
  } src_t;

  localparam int AXIS_MIN = -128;
  localparam int AXIS_MAX = 127;

  typedef logic signed [8:0] axis_t;

endpackage : atari_input_pkg
`default_nettype wire

// File: rtl/axis_accum.sv
`default_nettype none
// ============================================================================
// Module   : axis_accum
// Purpose  : One mouse axis: clamps a sign-extended report delta to
//            +/-STEP_LIMIT and adds it to the accumulator with saturation to
//            [AXIS_MIN, AXIS_MAX]. Purely combinational.
// Ports    : acc      - current accumulator value
//            sign     - delta sign bit from the mouse report
//            mag      - delta byte from the mouse report
//            acc_next - saturated accumulator after applying the delta
// Revision : 1.0 - initial release
// ============================================================================
module axis_accum
  import atari_input_pkg::*;
#(
  parameter int STEP_LIMIT = 10
) (
  input  axis_t      acc,
  input  logic       sign,
  input  logic [7:0] mag,
  output axis_t      acc_next
);

  localparam logic signed [9:0] LIM_POS = 10'(STEP_LIMIT);
  localparam logic signed [9:0] LIM_NEG = -10'(STEP_LIMIT);
  localparam logic signed [9:0] SAT_MAX = 10'(AXIS_MAX);
  localparam logic signed [9:0] SAT_MIN = 10'(AXIS_MIN);

  logic signed [9:0] delta_raw;
  logic signed [9:0] delta_clamped;
  logic signed [9:0] sum;

  always_comb begin
    // {sign, byte} is a 9-bit two's-complement value; widen to 10 bits so the
    // sum of two 9-bit operands can never wrap before saturation.
    delta_raw = {sign, sign, mag};

    delta_clamped = delta_raw;
    if (delta_raw > LIM_POS) begin
      delta_clamped = LIM_POS;
    end else if (delta_raw < LIM_NEG) begin
      delta_clamped = LIM_NEG;
    end

    sum = {acc[8], acc} + delta_clamped;

    acc_next = sum[8:0];
    if (sum > SAT_MAX) begin
      acc_next = SAT_MAX[8:0];
    end else if (sum < SAT_MIN) begin
      acc_next = SAT_MIN[8:0];
    end
  end

endmodule : axis_accum
`default_nettype wire

// File: rtl/input_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : input_source_arbiter
// Purpose  : Chooses which host device drives the core's paddle/analog and
//            fire inputs. A PS/2 mouse takes ownership when it sends reports;
//            the analog stick reclaims it whenever it moves; a halted CPU
//            forces joystick ownership. Mouse deltas accumulate per axis with
//            per-report clamping and saturation.
// Ports    : clk_sys   - system clock
//            reset_n   - asynchronous active-low reset
//            joy_0     - player-1 digital joystick bits
//            joya_0    - player-1 analog stick {Y[15:8], X[7:0]}, signed
//            ps2_mouse - {strobe, Y, X, 2'b0, Ysign, Xsign, 2'b0, buttons}
//            cpu_halt  - core halted
//            ax, ay    - registered signed analog X/Y to the core
//            j0        - registered digital/fire bits to the core
//            src       - registered owner: 0=JOY, 1=MOUSE, 2=HALT
// Revision : 1.0 - initial release
// ============================================================================
module input_source_arbiter
  import atari_input_pkg::*;
#(
  parameter int          STEP_LIMIT  = 10,
  parameter logic [23:0] IDLE_CYCLES = 24'd12_000_000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] joy_0,
  input  logic [15:0] joya_0,
  input  logic [24:0] ps2_mouse,
  input  logic        cpu_halt,
  output logic [7:0]  ax,
  output logic [7:0]  ay,
  output logic [7:0]  j0,
  output logic [1:0]  src
);

  src_t        state_q,  state_d;
  axis_t       mx_q,     mx_d;
  axis_t       my_q,     my_d;
  logic [23:0] idle_q,   idle_d;
  logic        strobe_q, strobe_d;
  logic        primed_q, primed_d;
  logic [7:0]  ax_q,     ax_d;
  logic [7:0]  ay_q,     ay_d;
  logic [7:0]  j0_q,     j0_d;
  logic [1:0]  src_q,    src_d;

  logic        report;
  logic [23:0] idle_inc;
  axis_t       acc_x_base;
  axis_t       acc_y_base;
  axis_t       mx_next;
  axis_t       my_next;
  logic        unused_ok;

  // Padding bits of the mouse word and the upper joystick byte carry nothing
  // this block uses.
  assign unused_ok = &{1'b0, ps2_mouse[7:6], ps2_mouse[3:2], joy_0[15:8]};

  // A report taken while the joystick owns the inputs starts a fresh
  // accumulation, whatever the accumulators happen to hold.
  assign acc_x_base = (state_q == SRC_JOY) ? '0 : mx_q;
  assign acc_y_base = (state_q == SRC_JOY) ? '0 : my_q;

  axis_accum #(.STEP_LIMIT(STEP_LIMIT)) u_axis_x (
    .acc      (acc_x_base),
    .sign     (ps2_mouse[4]),
    .mag      (ps2_mouse[15:8]),
    .acc_next (mx_next)
  );

  axis_accum #(.STEP_LIMIT(STEP_LIMIT)) u_axis_y (
    .acc      (acc_y_base),
    .sign     (ps2_mouse[5]),
    .mag      (ps2_mouse[23:16]),
    .acc_next (my_next)
  );

  always_comb begin
    state_d  = state_q;
    mx_d     = mx_q;
    my_d     = my_q;
    idle_d   = idle_q;
    strobe_d = ps2_mouse[24];
    primed_d = 1'b1;

    // The strobe level seen on the first cycle out of reset is only recorded,
    // never treated as a report.
    report   = primed_q && (ps2_mouse[24] != strobe_q);
    idle_inc = idle_q + 24'd1;

    if (cpu_halt) begin
      state_d = SRC_HALT;
      mx_d    = '0;
      my_d    = '0;
      idle_d  = '0;
    end else begin
      case (state_q)
        SRC_HALT: begin
          state_d = SRC_JOY;
        end
        SRC_JOY, SRC_MOUSE: begin
          if (joya_0 != 16'd0) begin
            state_d = SRC_JOY;
            mx_d    = '0;
            my_d    = '0;
            idle_d  = '0;
          end else if (report) begin
            state_d = SRC_MOUSE;
            mx_d    = mx_next;
            my_d    = my_next;
            idle_d  = '0;
          end else if (state_q == SRC_MOUSE) begin
            // Ownership lapses once IDLE_CYCLES-1 consecutive cycles have
            // passed without a report.
            if (idle_inc >= (IDLE_CYCLES - 24'd1)) begin
              state_d = SRC_JOY;
              mx_d    = '0;
              my_d    = '0;
              idle_d  = '0;
            end else begin
              idle_d  = idle_inc;
            end
          end
        end
        default: begin
          state_d = SRC_JOY;
          mx_d    = '0;
          my_d    = '0;
          idle_d  = '0;
        end
      endcase
    end

    // Outputs follow the owner registered in the previous cycle.
    if (state_q == SRC_MOUSE) begin
      ax_d = mx_q[7:0];
      ay_d = my_q[7:0];
      j0_d = {joy_0[7], ps2_mouse[1:0], joy_0[4:0]};
    end else begin
      ax_d = joya_0[7:0];
      ay_d = joya_0[15:8];
      j0_d = joy_0[7:0];
    end
    src_d = state_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SRC_JOY;
      mx_q     <= '0;
      my_q     <= '0;
      idle_q   <= '0;
      strobe_q <= 1'b0;
      primed_q <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
      j0_q     <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      idle_q   <= idle_d;
      strobe_q <= strobe_d;
      primed_q <= primed_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      j0_q     <= j0_d;
      src_q    <= src_d;
    end
  end

  assign ax  = ax_q;
  assign ay  = ay_q;
  assign j0  = j0_q;
  assign src = src_q;

endmodule : input_source_arbiter
`default_nettype wire

// File: tb/tb_input_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_source_arbiter
// Purpose  : Self-checking bench for input_source_arbiter: a stimulus table,
//            hand-written multi-cycle sequences and a randomized run, all
//            compared against a behavioural ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_source_arbiter;

  localparam int STEP = 10;
  localparam int IDLE = 16;

  logic        clk_sys;
  logic        reset_n;
  logic [15:0] joy_0;
  logic [15:0] joya_0;
  logic [24:0] ps2_mouse;
  logic        cpu_halt;
  logic [7:0]  ax;
  logic [7:0]  ay;
  logic [7:0]  j0;
  logic [1:0]  src;

  input_source_arbiter #(
    .STEP_LIMIT  (STEP),
    .IDLE_CYCLES (24'(IDLE))
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .joy_0     (joy_0),
    .joya_0    (joya_0),
    .ps2_mouse (ps2_mouse),
    .cpu_halt  (cpu_halt),
    .ax        (ax),
    .ay        (ay),
    .j0        (j0),
    .src       (src)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural model ----------------
  // Owner: 0 joystick, 1 mouse, 2 halt. Positions are plain integers.
  int         m_owner;
  int         m_x;
  int         m_y;
  int         m_quiet;      // consecutive report-free cycles while mouse owns
  logic       m_last_strobe;
  logic       m_seen_cycle;
  logic [7:0] e_ax;
  logic [7:0] e_ay;
  logic [7:0] e_j0;
  logic [1:0] e_src;

  function automatic int move_axis(int pos, logic s, logic [7:0] b);
    int d;
    d = s ? int'(b) - 256 : int'(b);
    if (d > STEP)  d = STEP;
    if (d < -STEP) d = -STEP;
    pos = pos + d;
    if (pos > 127)  pos = 127;
    if (pos < -128) pos = -128;
    return pos;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_x = 0; m_y = 0; m_quiet = 0;
    m_last_strobe = 1'b0; m_seen_cycle = 1'b0;
    e_ax = 8'h00; e_ay = 8'h00; e_j0 = 8'h00; e_src = 2'd0;
  endtask

  // Predicts what the DUT shows after the coming rising edge.
  task automatic model_step();
    logic got_report;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_owner == 1) begin
      e_ax = m_x[7:0];
      e_ay = m_y[7:0];
      e_j0 = {joy_0[7], ps2_mouse[1:0], joy_0[4:0]};
    end else begin
      e_ax = joya_0[7:0];
      e_ay = joya_0[15:8];
      e_j0 = joy_0[7:0];
    end
    e_src = 2'(m_owner);

    got_report    = m_seen_cycle && (ps2_mouse[24] != m_last_strobe);
    m_last_strobe = ps2_mouse[24];
    m_seen_cycle  = 1'b1;

    if (cpu_halt) begin
      m_owner = 2; m_x = 0; m_y = 0; m_quiet = 0;
    end else if (m_owner == 2) begin
      m_owner = 0;
    end else if (joya_0 != 16'd0) begin
      m_owner = 0; m_x = 0; m_y = 0; m_quiet = 0;
    end else if (got_report) begin
      if (m_owner == 0) begin
        m_x = 0; m_y = 0;
      end
      m_owner = 1;
      m_x = move_axis(m_x, ps2_mouse[4], ps2_mouse[15:8]);
      m_y = move_axis(m_y, ps2_mouse[5], ps2_mouse[23:16]);
      m_quiet = 0;
    end else if (m_owner == 1) begin
      m_quiet = m_quiet + 1;
      if (m_quiet >= IDLE - 1) begin
        m_owner = 0; m_x = 0; m_y = 0; m_quiet = 0;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_sys);
    #1;
    chk("model_ax",  ax,          e_ax);
    chk("model_ay",  ay,          e_ay);
    chk("model_j0",  j0,          e_j0);
    chk("model_src", {6'd0, src}, {6'd0, e_src});
  endtask

  function automatic logic [24:0] mk_mouse(logic stb, logic ys, logic [7:0] y,
                                           logic xs, logic [7:0] x, logic [1:0] btn);
    return {stb, y, x, 2'b00, ys, xs, 2'b00, btn};
  endfunction

  logic tb_strobe;

  task automatic report(logic xs, logic [7:0] x, logic ys, logic [7:0] y);
    tb_strobe = ~tb_strobe;
    ps2_mouse = mk_mouse(tb_strobe, ys, y, xs, x, 2'b00);
    tick();
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic        stb;
    logic        xs;
    logic [7:0]  x;
    logic        ys;
    logic [7:0]  y;
    logic [1:0]  btn;
    logic [15:0] joya;
    logic [7:0]  e_ax;
    logic [7:0]  e_ay;
    logic [7:0]  e_j0;
    logic [1:0]  e_src;
  } vec_t;

  vec_t vec [7];

  initial begin
    // Rows are one clock each; expectations are the outputs after that edge.
    vec[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'b10, 16'h0000, 8'h00, 8'h00, 8'hA5, 2'd0};
    vec[1] = '{1'b0, 1'b0, 8'h05, 1'b0, 8'hC8, 2'b10, 16'h0000, 8'h00, 8'h00, 8'hA5, 2'd0};
    vec[2] = '{1'b0, 1'b0, 8'h05, 1'b0, 8'hC8, 2'b10, 16'h0000, 8'h05, 8'h0A, 8'hC5, 2'd1};
    vec[3] = '{1'b1, 1'b0, 8'h28, 1'b0, 8'hC8, 2'b10, 16'h0000, 8'h05, 8'h0A, 8'hC5, 2'd1};
    vec[4] = '{1'b0, 1'b0, 8'h28, 1'b0, 8'hC8, 2'b10, 16'h0000, 8'h0F, 8'h14, 8'hC5, 2'd1};
    vec[5] = '{1'b1, 1'b0, 8'h28, 1'b0, 8'hC8, 2'b10, 16'h0000, 8'h19, 8'h1E, 8'hC5, 2'd1};
    vec[6] = '{1'b1, 1'b0, 8'h28, 1'b0, 8'hC8, 2'b10, 16'h0000, 8'h23, 8'h28, 8'hC5, 2'd1};

    // ---- reset with the strobe already high ----
    reset_n   = 1'b0;
    joy_0     = 16'h00A5;
    joya_0    = 16'h0033;
    cpu_halt  = 1'b0;
    tb_strobe = 1'b1;
    ps2_mouse = mk_mouse(tb_strobe, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00);
    model_reset();
    repeat (3) tick();
    chk("rst_ax",  ax,          8'h00);
    chk("rst_ay",  ay,          8'h00);
    chk("rst_j0",  j0,          8'h00);
    chk("rst_src", {6'd0, src}, 8'h00);

    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("held_strobe_src", {6'd0, src}, 8'h00);
      chk("held_strobe_ax",  ax,          8'h33);
    end

    // ---- table: first report and clamped steps ----
    joya_0 = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      ps2_mouse = mk_mouse(vec[i].stb, vec[i].ys, vec[i].y, vec[i].xs, vec[i].x, vec[i].btn);
      joya_0    = vec[i].joya;
      tick();
      chk($sformatf("vec%0d_ax", i),  ax,          vec[i].e_ax);
      chk($sformatf("vec%0d_ay", i),  ay,          vec[i].e_ay);
      chk($sformatf("vec%0d_j0", i),  j0,          vec[i].e_j0);
      chk($sformatf("vec%0d_src", i), {6'd0, src}, {6'd0, vec[i].e_src});
    end
    tb_strobe = vec[6].stb;

    // ---- negative saturation ----
    joya_0 = 16'h0001;
    tick();
    joya_0 = 16'h0000;
    repeat (13) report(1'b1, 8'h9C, 1'b0, 8'h00);
    tick();
    chk("sat_neg_ax", ax, 8'h80);
    report(1'b1, 8'h9C, 1'b0, 8'h00);
    tick();
    chk("sat_neg_nowrap_ax", ax, 8'h80);

    // ---- stick movement coincident with a report ----
    joya_0 = 16'h0100;
    report(1'b0, 8'h10, 1'b0, 8'h10);
    tick();
    chk("joya_src", {6'd0, src}, 8'h00);
    chk("joya_ay",  ay,          8'h01);
    chk("joya_ax",  ax,          8'h00);
    joya_0 = 16'h0000;
    tick();
    report(1'b0, 8'h03, 1'b0, 8'h00);
    tick();
    chk("after_joya_ax",  ax,          8'h03);
    chk("after_joya_src", {6'd0, src}, 8'h01);

    // ---- halt overrides everything ----
    cpu_halt = 1'b1;
    joya_0   = 16'h2207;
    repeat (5) report(1'b0, 8'h05, 1'b0, 8'h05);
    chk("halt_src", {6'd0, src}, 8'h02);
    chk("halt_ax",  ax,          8'h07);
    cpu_halt = 1'b0;
    tick();
    tick();
    chk("unhalt_src", {6'd0, src}, 8'h00);
    chk("unhalt_ax",  ax,          8'h07);
    chk("unhalt_ay",  ay,          8'h22);
    joya_0 = 16'h0000;
    repeat (3) tick();
    chk("halt_reports_ignored_src", {6'd0, src}, 8'h00);

    // ---- idle timeout boundary ----
    report(1'b0, 8'h01, 1'b0, 8'h00);
    repeat (15) tick();
    chk("idle15_src_pending", {6'd0, src}, 8'h01);
    tick();
    chk("idle15_src", {6'd0, src}, 8'h00);
    report(1'b0, 8'h01, 1'b0, 8'h00);
    repeat (14) tick();
    report(1'b0, 8'h01, 1'b0, 8'h00);
    repeat (10) tick();
    chk("idle14_src", {6'd0, src}, 8'h01);

    // ---- reset in the middle of accumulation ----
    report(1'b0, 8'h07, 1'b0, 8'h00);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ax",  ax,          8'h00);
    chk("midrst_src", {6'd0, src}, 8'h00);
    chk("midrst_j0",  j0,          8'h00);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    report(1'b0, 8'h04, 1'b0, 8'h00);
    tick();
    chk("postrst_ax",  ax,          8'h04);
    chk("postrst_src", {6'd0, src}, 8'h01);

    // ---- randomized run against the model ----
    for (int i = 0; i < 4000; i++) begin
      int toggle_odds;
      toggle_odds = ((i / 400) % 2 == 0) ? 3 : 20;
      cpu_halt = ($urandom_range(0, 99) < 2);
      joya_0   = ($urandom_range(0, 99) < 3) ? 16'($urandom) : 16'h0000;
      joy_0    = 16'($urandom);
      if ($urandom_range(0, toggle_odds - 1) == 0) tb_strobe = ~tb_strobe;
      ps2_mouse = mk_mouse(tb_strobe, 1'($urandom), 8'($urandom),
                           1'($urandom), 8'($urandom), 2'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_input_source_arbiter
`default_nettype wire
